// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types for the bit-serial subtractor controller: FSM state encoding
// and the default operand width.
package serial_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Requester-side handshake and operand/result bus of the serial subtractor.
// The master drives operands and start; the slave (controller) returns results.
interface serial_sub_ctrl_if #(
  parameter int WIDTH = serial_sub_ctrl_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface

// File: rtl/serial_sub_ctrl_fs.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the slice borrows.
module serial_sub_ctrl_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: sequences one full-subtractor cell LSB
// first over WIDTH cycles and owns operand/result shift registers and handshake.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_nxt;

  logic [WIDTH-1:0] sr_a;
  logic [WIDTH-1:0] sr_b;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             fs_d;
  logic             fs_bout;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  serial_sub_ctrl_fs u_fs (
    .a    (sr_a[0]),
    .b    (sr_b[0]),
    .bin  (brw),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred when a case arm does not mention state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: these are plain flops, not a memory array, so all of them are reset
  // to give a defined result value after reset or an aborted run.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_a     <= '0;
      sr_b     <= '0;
      sr_d     <= '0;
      brw      <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr_a <= bus.a;
            sr_b <= bus.b;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          sr_a <= {1'b0, sr_a[WIDTH-1:1]};
          sr_b <= {1'b0, sr_b[WIDTH-1:1]};
          sr_d <= {fs_d, sr_d[WIDTH-1:1]};
          brw  <= fs_bout;
          cnt  <= cnt + 1'b1;
          // The last slice's d bypasses sr_d so the result lands this same edge.
          if (last_bit) begin
            diff_q   <= {fs_d, sr_d[WIDTH-1:1]};
            borrow_q <= fs_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule
